// File: rtl/nanaseg_scan.sv
// Three-digit 7-segment scan driver: per-frame snapshot of the decoded digits,
// one digit per DIV-cycle slot, each slot opening with a BLANK-cycle dark window.
//
// state (slot) | meaning
// SLOT_ONES    | driving the ones digit (frame start, snapshot taken at cnt 0)
// SLOT_TENS    | driving the tens digit
// SLOT_HUND    | driving the hundreds digit (frame_tick armed at its last cycle)
// SLOT_BAD     | unreachable; recovers to SLOT_ONES with cnt 0
`timescale 1ns/1ps

module nanaseg_scan #(
   parameter int unsigned DIV            = 1000,
   parameter int unsigned BLANK          = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_dig1,
   input  logic [6:0] seg_dig2,
   input  logic [6:0] seg_dig3,
   input  logic [2:0] dig_en,
   output logic [6:0] seg_out,
   output logic [2:0] dig_sel,
   output logic       frame_tick
);

   localparam int unsigned     CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK);
   localparam logic [6:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]      DIG_OFF   = DIG_ACTIVE_LOW ? 3'h7 : 3'h0;

   typedef enum logic [1:0] {
      SLOT_ONES = 2'd0,
      SLOT_TENS = 2'd1,
      SLOT_HUND = 2'd2,
      SLOT_BAD  = 2'd3
   } slot_e;

   slot_e           slot_q, slot_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [6:0]      sh1_q, sh2_q, sh3_q;
   logic [2:0]      en_sh_q;
   logic            snap_ld;

   logic [6:0]      seg_out_q, seg_out_d;
   logic [2:0]      dig_sel_q, dig_sel_d;
   logic            tick_q, tick_d;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         slot_q <= SLOT_ONES;
      end else begin
         cnt_q  <= cnt_d;
         slot_q <= slot_d;
      end
   end

   // next state
   always_comb begin
      cnt_d  = cnt_q;
      slot_d = slot_q;
      if (slot_q == SLOT_BAD) begin
         cnt_d  = '0;
         slot_d = SLOT_ONES;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         case (slot_q)
            SLOT_ONES: slot_d = SLOT_TENS;
            SLOT_TENS: slot_d = SLOT_HUND;
            default:   slot_d = SLOT_ONES;
         endcase
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Snapshot only at frame start so a mid-frame value change never tears.
   assign snap_ld = (cnt_q == '0) && (slot_q == SLOT_ONES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh1_q   <= '0;
         sh2_q   <= '0;
         sh3_q   <= '0;
         en_sh_q <= '0;
      end else if (snap_ld) begin
         sh1_q   <= seg_dig1;
         sh2_q   <= seg_dig2;
         sh3_q   <= seg_dig3;
         en_sh_q <= dig_en;
      end
   end

   // output decode; BLANK >= 1 guarantees break-before-make between digits
   always_comb begin
      logic [2:0] sel_act;
      logic [6:0] pat_act;
      logic       en_act;
      sel_act = 3'b000;
      pat_act = 7'h00;
      en_act  = 1'b0;
      case (slot_q)
         SLOT_ONES: begin sel_act = 3'b001; pat_act = sh1_q; en_act = en_sh_q[0]; end
         SLOT_TENS: begin sel_act = 3'b010; pat_act = sh2_q; en_act = en_sh_q[1]; end
         SLOT_HUND: begin sel_act = 3'b100; pat_act = sh3_q; en_act = en_sh_q[2]; end
         default:   begin sel_act = 3'b000; pat_act = 7'h00; en_act = 1'b0;       end
      endcase
      if ((cnt_q >= CNT_BLANK) && en_act) begin
         dig_sel_d = sel_act ^ {3{DIG_ACTIVE_LOW}};
         seg_out_d = pat_act ^ {7{SEG_ACTIVE_LOW}};
      end else begin
         dig_sel_d = DIG_OFF;
         seg_out_d = SEG_OFF;
      end
      tick_d = (cnt_q == CNT_LAST) && (slot_q == SLOT_HUND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_sel_q <= DIG_OFF;
         seg_out_q <= SEG_OFF;
         tick_q    <= 1'b0;
      end else begin
         dig_sel_q <= dig_sel_d;
         seg_out_q <= seg_out_d;
         tick_q    <= tick_d;
      end
   end

   assign dig_sel    = dig_sel_q;
   assign seg_out    = seg_out_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_nanaseg_scan.sv
// Bench for nanaseg_scan: two instances (DIV=8/BLANK=2 active-low, DIV=2/BLANK=1
// active-high) checked every cycle against a frame-position model plus literals.
`timescale 1ns/1ps

module tb_nanaseg_scan;

   logic       clk;
   logic       rst;
   logic [6:0] seg_dig1, seg_dig2, seg_dig3;
   logic [2:0] dig_en;
   logic [6:0] seg_out_a, seg_out_b;
   logic [2:0] dig_sel_a, dig_sel_b;
   logic       frame_tick_a, frame_tick_b;

   int n_cmp = 0;
   int n_err = 0;

   nanaseg_scan #(.DIV(8), .BLANK(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_a (
      .clk(clk), .rst(rst),
      .seg_dig1(seg_dig1), .seg_dig2(seg_dig2), .seg_dig3(seg_dig3), .dig_en(dig_en),
      .seg_out(seg_out_a), .dig_sel(dig_sel_a), .frame_tick(frame_tick_a)
   );

   nanaseg_scan #(.DIV(2), .BLANK(1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut_b (
      .clk(clk), .rst(rst),
      .seg_dig1(seg_dig1), .seg_dig2(seg_dig2), .seg_dig3(seg_dig3), .dig_en(dig_en),
      .seg_out(seg_out_b), .dig_sel(dig_sel_b), .frame_tick(frame_tick_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // edges since reset release, and the inputs seen at the latest edge
   int          n_q;
   logic [23:0] in_q;

   always @(posedge clk or posedge rst) begin
      if (rst) n_q <= 0;
      else     n_q <= n_q + 1;
   end

   always @(posedge clk) in_q <= {dig_en, seg_dig3, seg_dig2, seg_dig1};

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Output after edge e shows frame position e mod 3*div: slot = pos/div, cycle = pos%div.
   function automatic logic [10:0] model_out(input int e, input int div, input int blank,
                                             input logic [23:0] snap, input bit sal, input bit dal);
      int         p, s, c;
      logic [2:0] dig;
      logic [6:0] seg;
      logic       tk;
      p   = e % (3 * div);
      s   = p / div;
      c   = p % div;
      dig = 3'b000;
      seg = 7'h00;
      if (c >= blank && snap[21 + s]) begin
         dig = 3'b001 << s;
         seg = snap[7 * s +: 7];
      end
      tk = (p == 3 * div - 1);
      if (dal) dig = ~dig;
      if (sal) seg = ~seg;
      return {tk, dig, seg};
   endfunction

   initial begin
      logic [23:0] snap_a, snap_b;
      logic [10:0] exp_a, exp_b;
      int          e;
      snap_a = '0;
      snap_b = '0;
      forever begin
         @(negedge clk);
         if (rst || n_q == 0) begin
            exp_a = {1'b0, 3'b111, 7'h7F};
            exp_b = {1'b0, 3'b000, 7'h00};
         end else begin
            e = n_q - 1;
            if (e % 24 == 0) snap_a = in_q;
            if (e % 6 == 0)  snap_b = in_q;
            exp_a = model_out(e, 8, 2, snap_a, 1'b1, 1'b1);
            exp_b = model_out(e, 2, 1, snap_b, 1'b0, 1'b0);
         end
         check("scan_a", {frame_tick_a, dig_sel_a, seg_out_a}, exp_a);
         check("scan_b", {frame_tick_b, dig_sel_b, seg_out_b}, exp_b);
         check("onehot_b", 11'($countones(dig_sel_b) <= 1), 11'd1);
      end
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #3;
   endtask

   task automatic lit_a(input string name, input logic [2:0] dig, input logic [6:0] seg);
      check(name, {1'b0, dig_sel_a, seg_out_a}, {1'b0, dig, seg});
   endtask

   initial begin
      int ticks;
      rst      = 1'b1;
      seg_dig1 = 7'h3F;
      seg_dig2 = 7'h06;
      seg_dig3 = 7'h5B;
      dig_en   = 3'b111;
      step(3);
      check("rst_a", {frame_tick_a, dig_sel_a, seg_out_a}, {1'b0, 3'b111, 7'h7F});
      check("rst_b", {frame_tick_b, dig_sel_b, seg_out_b}, {1'b0, 3'b000, 7'h00});
      rst = 1'b0;

      step(2);                        // edge 1
      lit_a("blank_a_s0", 3'b111, 7'h7F);
      check("lit_b_s0", {frame_tick_b, dig_sel_b, seg_out_b}, {1'b0, 3'b001, 7'h3F});
      step(1);                        // edge 2
      lit_a("ones_a", 3'b110, 7'h40);
      step(6);                        // edge 8
      lit_a("blank_a_s1", 3'b111, 7'h7F);
      step(2);                        // edge 10
      lit_a("tens_a", 3'b101, 7'h79);
      seg_dig3 = 7'h4F;
      step(8);                        // edge 18
      lit_a("hund_snap_old", 3'b011, 7'h24);
      step(24);                       // edge 42
      lit_a("hund_snap_new", 3'b011, 7'h30);
      dig_en = 3'b001;
      step(8);                        // edge 50
      lit_a("en_ones", 3'b110, 7'h40);
      dig_en = 3'b111;
      step(8);                        // edge 58
      lit_a("en_tens_dark", 3'b111, 7'h7F);
      step(8);                        // edge 66
      lit_a("en_hund_dark", 3'b111, 7'h7F);
      step(16);                       // edge 82
      lit_a("en_restored", 3'b101, 7'h79);

      ticks = 0;
      for (int i = 0; i < 2400; i++) begin
         step(1);
         if (frame_tick_a) ticks++;
      end
      check("tick_count", 11'(ticks), 11'd100);

      // now at edge 2482: slot 1, cnt 2 -- async reset mid-slot
      rst = 1'b1;
      #1;
      check("async_rst_a", {frame_tick_a, dig_sel_a, seg_out_a}, {1'b0, 3'b111, 7'h7F});
      check("async_rst_b", {frame_tick_b, dig_sel_b, seg_out_b}, {1'b0, 3'b000, 7'h00});
      step(2);
      rst = 1'b0;
      step(3);                        // edge 2
      lit_a("restart_ones", 3'b110, 7'h40);
      step(21);                       // edge 23
      check("tick_lit", 11'(frame_tick_a), 11'd1);
      step(1);
      check("tick_low", 11'(frame_tick_a), 11'd0);
      step(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
